// File: rtl/csr_regfile.sv
// csr_regfile: RV32 machine-mode CSR storage, trap/mret state update and interrupt request.
// Build option: define CSR_COUNTERS_EN to implement the 64-bit mcycle/minstret counters.

module csr_regfile #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          HART_ID   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_rd_en,
    input  logic            csr_wr_en,
    input  logic [11:0]     csr_idx,
    input  logic [XLEN-1:0] csr_cmd_wdata,
    output logic [XLEN-1:0] csr_cmd_rdata,
    output logic            csr_access_ilgl,
    input  logic            instret_inc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret_valid,
    input  logic            irq_ext,
    input  logic            irq_tmr,
    input  logic            irq_sw,
    output logic [XLEN-1:0] csr_mtvec,
    output logic [XLEN-1:0] csr_mepc,
    output logic            csr_irq_req
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    logic            mstatus_mie_q, mstatus_mie_d;
    logic            mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]      mie_q, mie_d;  // {MEIE, MTIE, MSIE}
    logic [XLEN-1:2] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:1] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;

    logic [2:0]      mip;
    logic            implemented;
    logic            sw_wr;
    logic [XLEN-1:0] rd_val;
    logic            unused_trap_pc0;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
`else
    logic        unused_instret;
    assign unused_instret = instret_inc;
`endif

    assign unused_trap_pc0 = trap_pc[0];
    assign mip = {irq_ext, irq_tmr, irq_sw};

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        implemented = 1'b1;
        rd_val      = '0;
        case (csr_idx)
            ADDR_MSTATUS:  rd_val = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
            ADDR_MISA:     rd_val = 32'h4000_0100;
            ADDR_MIE:      {rd_val[11], rd_val[7], rd_val[3]} = mie_q;
            ADDR_MTVEC:    rd_val = {mtvec_q, 2'b00};
            ADDR_MSCRATCH: rd_val = mscratch_q;
            ADDR_MEPC:     rd_val = {mepc_q, 1'b0};
            ADDR_MCAUSE:   rd_val = mcause_q;
            ADDR_MTVAL:    rd_val = mtval_q;
            ADDR_MIP:      {rd_val[11], rd_val[7], rd_val[3]} = mip;
`ifdef CSR_COUNTERS_EN
            ADDR_MCYCLE:    rd_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   rd_val = mcycle_q[63:32];
            ADDR_MINSTRET:  rd_val = minstret_q[31:0];
            ADDR_MINSTRETH: rd_val = minstret_q[63:32];
`else
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: rd_val = '0;
`endif
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: rd_val = '0;
            ADDR_MHARTID:  rd_val = XLEN'(HART_ID);
            default:       implemented = 1'b0;
        endcase
    end

    assign csr_access_ilgl = (csr_rd_en | csr_wr_en) &
                             (~implemented | (csr_wr_en & (csr_idx[11:10] == 2'b11)));
    assign csr_cmd_rdata   = csr_rd_en ? rd_val : '0;

    // Trap and mret own the cycle: a concurrent software write is dropped entirely.
    assign sw_wr = csr_wr_en & ~csr_access_ilgl & ~trap_valid & ~mret_valid;

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (trap_valid) begin
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
            mepc_d         = trap_pc[XLEN-1:1];
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
        end else if (mret_valid) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end else if (sw_wr) begin
            case (csr_idx)
                ADDR_MSTATUS: begin
                    mstatus_mie_d  = csr_cmd_wdata[3];
                    mstatus_mpie_d = csr_cmd_wdata[7];
                end
                ADDR_MIE:      mie_d      = {csr_cmd_wdata[11], csr_cmd_wdata[7], csr_cmd_wdata[3]};
                ADDR_MTVEC:    mtvec_d    = csr_cmd_wdata[XLEN-1:2];
                ADDR_MSCRATCH: mscratch_d = csr_cmd_wdata;
                ADDR_MEPC:     mepc_d     = csr_cmd_wdata[XLEN-1:1];
                ADDR_MCAUSE:   mcause_d   = csr_cmd_wdata;
                ADDR_MTVAL:    mtval_d    = csr_cmd_wdata;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= MTVEC_RST[XLEN-1:2];
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    // A written half takes wdata; the other half keeps the full 64-bit increment of this cycle.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret_inc};
        if (sw_wr) begin
            case (csr_idx)
                ADDR_MCYCLE:    mcycle_d[31:0]    = csr_cmd_wdata;
                ADDR_MCYCLEH:   mcycle_d[63:32]   = csr_cmd_wdata;
                ADDR_MINSTRET:  minstret_d[31:0]  = csr_cmd_wdata;
                ADDR_MINSTRETH: minstret_d[63:32] = csr_cmd_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`endif

    assign csr_mtvec   = {mtvec_q, 2'b00};
    assign csr_mepc    = {mepc_q, 1'b0};
    assign csr_irq_req = mstatus_mie_q & |(mip & mie_q);

endmodule
